bus_ram_responder: RTL and testbench
====================================

# bus_ram_responder

Word-organised RAM that answers the CPU's memory bus as its slave/responder: it accepts the `read`/`write` requests, `address`, `writedata` and `byteenable` that the CPU drives, and returns `readdata` and `waitrequest`. It inserts configurable wait states, applies byte-enabled writes, and flags protocol or range errors. It sits in the testbench/SoC wrapper as the instruction and data memory behind the CPU's single shared bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index width; array holds 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, 32'hBFC0_0000: byte address of word 0.
- `WAIT_CYCLES`, 1: fixed cycles of `waitrequest` high per transaction; legal range 1..15.
- `INIT_FILE`, "": hex file loaded with `$readmemh` at elaboration; an empty string leaves the contents X.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `address` in 32: byte address; bits [1:0] are ignored.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `byteenable` in 4: lane enables; bit0 maps to [7:0] and bit3 maps to [31:24].
- `waitrequest` out 1: high means the request is not yet accepted.
- `readdata` out 32: read data, valid in the cycle where `read`=1 and `waitrequest`=0.
- `bus_error` out 1: sticky error flag; cleared only by `reset`.

## Operation
- FSM states: IDLE, WAIT, ACK. Wait counter: 4 bits.
- IDLE:
  - `read^write` = 1: `waitrequest`=1 and the counter is cleared. Go to ACK if the wait target is 1, otherwise go to WAIT.
  - `read&write` = 1: set `bus_error` and behave as a wait-state sequence with no access performed.
  - No request: `waitrequest`=0 and the state stays IDLE.
- WAIT:
  - `waitrequest`=1 and the counter increments each cycle.
  - When counter == target-1, go to ACK.
  - Request dropped during WAIT (protocol violation): set `bus_error`, return to IDLE, perform no access.
- Read data capture: on the edge entering ACK, latch `mem[idx]` into the `readdata` register.
  - idx = (`address` - `BASE_ADDR`) >> 2.
- ACK: `waitrequest`=0 and the next state is IDLE.
  - Write: on the ACK edge, lanes with `byteenable[i]`=1 take `writedata[8i+7:8i]`; the other lanes are unchanged.
  - `byteenable`=4'b0000 on a write completes the handshake with no change to memory.
- Out of range: (`address` - `BASE_ADDR`) >> 2 ≥ 2^ADDR_WIDTH, or `address` < `BASE_ADDR`.
  - Read returns 32'h0000_0000.
  - Write is discarded.
  - `bus_error` is set.
  - The handshake completes normally.
- Back-to-back requests: a request still asserted in the cycle after ACK is a new transaction and starts again from IDLE with full wait states.
- Master obligations: `address`, `writedata` and `byteenable` are held stable while `waitrequest`=1. The responder samples them only at the ACK edge for writes and at the ACK-entry edge for reads.

## Timing
- Reset values while `reset`=1:
  - state = IDLE; counter = 0.
  - `waitrequest` = 1, to hold off the master.
  - `readdata` = 0; `bus_error` = 0.
  - Memory contents are retained, not cleared.
- Reset release: with no request pending, `waitrequest` falls to 0 combinationally after `reset` deasserts.
- Reset mid-transaction: the transaction is abandoned and no write is committed.
- Latency: a request first seen at cycle 0 has `waitrequest` high for cycles 0..W-1 and low at cycle W, where it completes.
- `waitrequest` is combinational from state and `read|write`; `readdata` is registered.

## Configuration
- `BUS_RAM_RANDOM_WAIT_EN` defined:
  - The per-transaction wait target is 1 + `lfsr[1:0]`, giving 1..4 cycles.
  - `lfsr` is an 8-bit Fibonacci LFSR with taps 8,6,5,4, reset to 8'hA5, advanced once per completed transaction.
  - `WAIT_CYCLES` is ignored.
- Macro undefined: the target is always `WAIT_CYCLES` and no LFSR is built.

## Test plan
- WAIT_CYCLES=1; write 32'hDEADBEEF, `byteenable`=4'hF, address 32'hBFC0_0010; then read the same address -> each transaction has `waitrequest` high for 1 cycle, and the read returns 32'hDEADBEEF.
- Word preset to 32'h11223344; write 32'hAABBCCDD with `byteenable`=4'b0101 -> read returns 32'h11BB33DD.
- WAIT_CYCLES=3; `read` held for 4 cycles -> `waitrequest` is 1,1,1,0; back-to-back continuation repeats the pattern.
- Read from 32'h0000_0000 (below BASE) -> `readdata`=0 and `bus_error`=1, staying 1 after later good accesses until `reset`.
- `read` and `write` asserted together, or `read` dropped mid-WAIT -> `bus_error`=1 and memory unchanged.
- `reset` pulsed during WAIT of a write -> target word unchanged, `waitrequest`=1 during reset, and 0 after release.
- With `BUS_RAM_RANDOM_WAIT_EN`: 8 reads after reset give wait lengths matching the LFSR sequence from 8'hA5, each within 1..4.

Source files
------------

// File: rtl/bus_ram_responder.sv
// Word-organised RAM slave on the CPU bus with fixed (or LFSR-random, when
// BUS_RAM_RANDOM_WAIT_EN is defined) wait states, byte-enabled writes and a sticky error flag.
module bus_ram_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              count;
    logic [3:0]              next_count;
    logic [3:0]              count_inc;
    logic [3:0]              target;
    logic                    op_write;
    logic                    op_bad;
    logic                    acc_write;
    logic                    acc_bad;
    logic                    start;
    logic                    set_err;
    logic                    fsm_wait;
    logic [31:0]             word_off;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_range;

    // Word offset from the base; address bits [1:0] drop out of the shift.
    assign word_off = (address - BASE_ADDR) >> 2;
    assign idx      = word_off[ADDR_WIDTH-1:0];
    assign in_range = (address >= BASE_ADDR) &&
                      (word_off[31:ADDR_WIDTH] == {(32-ADDR_WIDTH){1'b0}});

`ifdef BUS_RAM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    assign target = {2'b00, lfsr[1:0]} + 4'd1;

    // Fibonacci LFSR (taps 8,6,5,4), stepped once per completed transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (state == ACK) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end else begin
            lfsr <= lfsr;
        end
    end
`else
    assign target = 4'(WAIT_CYCLES);
`endif

    assign count_inc = count + 4'd1;

    // In IDLE the request being accepted is the live one; later it is the latched one.
    assign acc_write = (state == IDLE) ? write : op_write;
    assign acc_bad   = (state == IDLE) ? (read & write) : op_bad;

    // Next-state, wait counter and handshake decode.
    always_comb begin
        next_state = state;
        next_count = count;
        fsm_wait   = 1'b1;
        start      = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (read | write) begin
                    fsm_wait   = 1'b1;
                    next_count = 4'd0;
                    start      = 1'b1;
                    set_err    = read & write;
                    next_state = (target == 4'd1) ? ACK : WAIT;
                end else begin
                    fsm_wait   = 1'b0;
                    next_state = IDLE;
                end
            end
            WAIT: begin
                fsm_wait = 1'b1;
                if (!(read | write)) begin
                    set_err    = 1'b1;
                    next_count = 4'd0;
                    next_state = IDLE;
                end else begin
                    next_count = count_inc;
                    next_state = (count_inc == (target - 4'd1)) ? ACK : WAIT;
                end
            end
            ACK: begin
                fsm_wait   = 1'b0;
                next_state = IDLE;
            end
            default: begin
                fsm_wait   = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    assign waitrequest = reset | fsm_wait;

    // State, latched request kind, read data capture and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            op_write  <= 1'b0;
            op_bad    <= 1'b0;
            readdata  <= 32'h0000_0000;
            bus_error <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (start) begin
                op_write <= write;
                op_bad   <= read & write;
            end else begin
                op_write <= op_write;
                op_bad   <= op_bad;
            end
            if (next_state == ACK && state != ACK && !acc_bad) begin
                if (!acc_write) begin
                    readdata <= in_range ? mem[idx] : 32'h0000_0000;
                end else begin
                    readdata <= readdata;
                end
                bus_error <= bus_error | ~in_range;
            end else begin
                readdata  <= readdata;
                bus_error <= bus_error | set_err;
            end
        end
    end

    // Byte-lane write on the ACK edge; memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && state == ACK && op_write && !op_bad && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench for bus_ram_responder: one instance with 1 wait cycle and one with 3.
module tb_bus_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read1, write1, read3, write3;
    logic        wr1, wr3, err1, err3;
    logic [31:0] rd1, rd3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] lfsr_m [2];

    always #5 clk = ~clk;

    bus_ram_responder #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .read(read1), .write(write1),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wr1),
        .readdata(rd1), .bus_error(err1));

    bus_ram_responder #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .address(address), .read(read3), .write(write3),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wr3),
        .readdata(rd3), .bus_error(err3));

    function automatic logic get_wr(input bit i3);
        return i3 ? wr3 : wr1;
    endfunction

    function automatic logic [31:0] get_rd(input bit i3);
        return i3 ? rd3 : rd1;
    endfunction

    function automatic int exp_wait(input bit i3);
`ifdef BUS_RAM_RANDOM_WAIT_EN
        return 1 + int'(lfsr_m[i3][1:0]);
`else
        return i3 ? 3 : 1;
`endif
    endfunction

    task automatic advance(input bit i3);
        logic [7:0] l;
        l = lfsr_m[i3];
        lfsr_m[i3] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endtask

    task automatic set_req(input bit i3, input bit r, input bit w);
        if (i3) begin read3 = r; write3 = w; end
        else    begin read1 = r; write1 = w; end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        lfsr_m[0] = 8'hA5;
        lfsr_m[1] = 8'hA5;
    endtask

    // Runs one transaction; waits = cycles with waitrequest high (99 on timeout).
    task automatic xfer(input bit i3, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int waits, output logic [31:0] rdv);
        bit done = 1'b0;
        address = a; writedata = d; byteenable = be;
        set_req(i3, r, w);
        waits = 0;
        rdv = 32'hxxxx_xxxx;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (get_wr(i3) === 1'b0) begin
                rdv = get_rd(i3);
                done = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) waits = 99;
        else advance(i3);
        @(posedge clk); #1;
        set_req(i3, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0);
        address = 32'hBFC0_0000; writedata = 32'h0; byteenable = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (wr1 !== 1'b1) $display("FAIL rst_wr1 got %b want 1", wr1); else pass_cnt++;
        total_cnt++; if (wr3 !== 1'b1) $display("FAIL rst_wr3 got %b want 1", wr3); else pass_cnt++;
        total_cnt++; if (rd1 !== 32'h0) $display("FAIL rst_rd1 got %h want 0", rd1); else pass_cnt++;
        total_cnt++; if (err1 !== 1'b0) $display("FAIL rst_err1 got %b want 0", err1); else pass_cnt++;
        total_cnt++; if (err3 !== 1'b0) $display("FAIL rst_err3 got %b want 0", err3); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        lfsr_m[0] = 8'hA5;
        lfsr_m[1] = 8'hA5;
        #1;
        total_cnt++; if (wr1 !== 1'b0) $display("FAIL rel_wr1 got %b want 0", wr1); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int w, ew;
        logic [31:0] r;
        ew = exp_wait(1'b0);
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_0010, 32'hDEADBEEF, 4'hF, w, r);
        total_cnt++; if (w !== ew) $display("FAIL wr_wait got %0d want %0d", w, ew); else pass_cnt++;
        ew = exp_wait(1'b0);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0010, 32'h0, 4'h0, w, r);
        total_cnt++; if (w !== ew) $display("FAIL rd_wait got %0d want %0d", w, ew); else pass_cnt++;
        total_cnt++; if (r !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", r); else pass_cnt++;
        total_cnt++; if (err1 !== 1'b0) $display("FAIL wr_err got %b want 0", err1); else pass_cnt++;
    endtask

    task automatic test_byteenable();
        int w;
        logic [31:0] r;
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_0020, 32'h11223344, 4'hF, w, r);
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_0020, 32'hAABBCCDD, 4'b0101, w, r);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0020, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h11BB33DD) $display("FAIL be_0101 got %h want 11bb33dd", r); else pass_cnt++;
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_0020, 32'hFFFFFFFF, 4'b0000, w, r);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0020, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h11BB33DD) $display("FAIL be_0000 got %h want 11bb33dd", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w, ew;
        logic [31:0] r;
        ew = exp_wait(1'b1);
        xfer(1'b1, 1'b0, 1'b1, 32'hBFC0_0010, 32'h55AA55AA, 4'hF, w, r);
        total_cnt++; if (w !== ew) $display("FAIL w3_wait got %0d want %0d", w, ew); else pass_cnt++;
        address = 32'hBFC0_0010;
        read3 = 1'b1;
        for (int t = 0; t < 2; t++) begin
            ew = exp_wait(1'b1);
            for (int c = 0; c <= ew; c++) begin
                @(negedge clk);
                total_cnt++;
                if (wr3 !== (c < ew)) $display("FAIL b2b_wr t%0d c%0d got %b want %b", t, c, wr3, (c < ew));
                else pass_cnt++;
                if (c == ew) begin
                    total_cnt++;
                    if (rd3 !== 32'h55AA55AA) $display("FAIL b2b_rd t%0d got %h want 55aa55aa", t, rd3);
                    else pass_cnt++;
                end
                @(posedge clk); #1;
            end
            advance(1'b1);
        end
        read3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_range();
        int w, ew;
        logic [31:0] r;
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h0A0B0C0D, 4'hF, w, r);
        xfer(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h0) $display("FAIL below_rd got %h want 0", r); else pass_cnt++;
        total_cnt++; if (err1 !== 1'b1) $display("FAIL below_err got %b want 1", err1); else pass_cnt++;
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_1000, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h0) $display("FAIL above_rd got %h want 0", r); else pass_cnt++;
        ew = exp_wait(1'b0);
        xfer(1'b0, 1'b0, 1'b1, 32'hBFC0_1000, 32'hFFFFFFFF, 4'hF, w, r);
        total_cnt++; if (w !== ew) $display("FAIL oor_wr_wait got %0d want %0d", w, ew); else pass_cnt++;
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h0A0B0C0D) $display("FAIL oor_alias got %h want 0a0b0c0d", r); else pass_cnt++;
        total_cnt++; if (err1 !== 1'b1) $display("FAIL err_sticky got %b want 1", err1); else pass_cnt++;
        pulse_reset();
        total_cnt++; if (err1 !== 1'b0) $display("FAIL err_clear got %b want 0", err1); else pass_cnt++;
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h0A0B0C0D) $display("FAIL mem_retain got %h want 0a0b0c0d", r); else pass_cnt++;
    endtask

    task automatic test_protocol();
        int w;
        logic [31:0] r;
        xfer(1'b1, 1'b0, 1'b1, 32'hBFC0_0030, 32'h12345678, 4'hF, w, r);
        total_cnt++; if (err3 !== 1'b0) $display("FAIL pre_err got %b want 0", err3); else pass_cnt++;
        xfer(1'b1, 1'b1, 1'b1, 32'hBFC0_0030, 32'hFFFFFFFF, 4'hF, w, r);
        total_cnt++; if (err3 !== 1'b1) $display("FAIL rw_err got %b want 1", err3); else pass_cnt++;
        pulse_reset();
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC0_0030, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'h12345678) $display("FAIL rw_mem got %h want 12345678", r); else pass_cnt++;
        total_cnt++; if (err3 !== 1'b0) $display("FAIL good_err got %b want 0", err3); else pass_cnt++;
        if (exp_wait(1'b1) >= 2) begin
            address = 32'hBFC0_0030;
            read3 = 1'b1;
            @(posedge clk); #1;
            read3 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            total_cnt++; if (err3 !== 1'b1) $display("FAIL drop_err got %b want 1", err3); else pass_cnt++;
            total_cnt++; if (wr3 !== 1'b0) $display("FAIL drop_wr got %b want 0", wr3); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int w;
        logic [31:0] r;
        xfer(1'b1, 1'b0, 1'b1, 32'hBFC0_0040, 32'hCAFEF00D, 4'hF, w, r);
        address = 32'hBFC0_0040; writedata = 32'h0BADF00D; byteenable = 4'hF;
        write3 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (wr3 !== 1'b1) $display("FAIL midrst_wr got %b want 1", wr3); else pass_cnt++;
        write3 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        lfsr_m[0] = 8'hA5;
        lfsr_m[1] = 8'hA5;
        #1;
        total_cnt++; if (wr3 !== 1'b0) $display("FAIL midrst_rel got %b want 0", wr3); else pass_cnt++;
        @(posedge clk); #1;
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC0_0040, 32'h0, 4'h0, w, r);
        total_cnt++; if (r !== 32'hCAFEF00D) $display("FAIL midrst_mem got %h want cafef00d", r); else pass_cnt++;
    endtask

    task automatic test_lfsr();
`ifdef BUS_RAM_RANDOM_WAIT_EN
        int w, ew;
        logic [31:0] r;
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            ew = exp_wait(1'b0);
            xfer(1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, w, r);
            total_cnt++;
            if (w !== ew || w < 1 || w > 4) $display("FAIL lfsr_wait k%0d got %0d want %0d", k, w, ew);
            else pass_cnt++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_back_to_back();
        test_range();
        test_protocol();
        test_reset_mid();
        test_lfsr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
